// File: rtl/mvm_pkg.sv
// Shared types and helpers for the streaming matrix-vector engine.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  // Accumulator width that cannot overflow over 2**col_w full-precision products.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned col_w);
    return 2 * dw + col_w;
  endfunction

endpackage

// File: rtl/mvm_stream_engine_if.sv
// Vector-in / result-out valid-ready streams of the matrix-vector engine.
interface mvm_stream_engine_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 16,
  parameter int unsigned ACC_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  relu_en;
  logic [COLS*DW-1:0]    x_vector_flat;
  logic                  out_valid;
  logic                  out_ready;
  logic [ROWS*ACC_W-1:0] result_flat;

  modport master (
    output in_valid, relu_en, x_vector_flat, out_ready,
    input  in_ready, out_valid, result_flat
  );

  modport slave (
    input  in_valid, relu_en, x_vector_flat, out_ready,
    output in_ready, out_valid, result_flat
  );
endinterface

// File: rtl/mvm_sat_relu.sv
// Narrows one wide accumulator to the output width with optional ReLU,
// then either saturation or plain truncation.
module mvm_sat_relu #(
  parameter int unsigned AW     = 20,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned SAT_EN = 1
) (
  input  logic signed [AW-1:0] acc_i,
  input  logic                 relu_i,
  output logic [ACC_W-1:0]     y_o
);
  localparam logic signed [AW-1:0] MAX_V = AW'((64'(1) << (ACC_W - 1)) - 64'(1));
  localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

  always_comb begin
    y_o = acc_i[ACC_W-1:0];
    if (relu_i && acc_i[AW-1]) begin
      y_o = '0;
    end else if (SAT_EN != 0) begin
      if (acc_i > MAX_V)      y_o = MAX_V[ACC_W-1:0];
      else if (acc_i < MIN_V) y_o = MIN_V[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/mvm_stream_engine.sv
// Streaming ROWS x COLS matrix-vector engine: double-buffered weight banks,
// one column per cycle across ROWS parallel MACs, valid/ready on both ends.
module mvm_stream_engine
  import mvm_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 16,
  parameter int unsigned ROW_W  = 3,
  parameter int unsigned COL_W  = 4,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned SAT_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pre_valid,
  input  logic [ROW_W+COL_W-1:0] pre_addr,
  input  logic signed [DW-1:0]   pre_data,
  input  logic                   bank_swap,
  mvm_stream_engine_if.slave     s,
  output logic                   active_bank,
  output logic                   busy
);
  localparam int unsigned AW = acc_width(DW, COL_W);

  state_e                state_q, state_d;
  logic                  active_bank_q, active_bank_d;
  logic                  swap_pending_q, swap_pending_d;
  logic signed [DW-1:0]  w_q [2][ROWS][COLS];
  logic [COLS*DW-1:0]    x_q;
  logic                  relu_q;
  logic [COL_W-1:0]      col_q, col_d;
  logic signed [AW-1:0]  acc_q [ROWS];
  logic signed [AW-1:0]  acc_d [ROWS];
  logic signed [AW-1:0]  acc_sum_c [ROWS];
  logic signed [2*DW-1:0] prod_c [ROWS];
  logic signed [DW-1:0]  x_col_c;
  logic [ROWS*ACC_W-1:0] res_q, res_d, res_sat_c;
  logic                  out_valid_q, out_valid_d, busy_q;
  logic                  in_ready_c, accept_c;
  logic [ROW_W-1:0]      pre_row;
  logic [COL_W-1:0]      pre_col;

  assign pre_row = pre_addr[ROW_W+COL_W-1:COL_W];
  assign pre_col = pre_addr[COL_W-1:0];

  // A pending swap, or one requested this very cycle, holds off new vectors.
  assign in_ready_c = (state_q == IDLE) && !swap_pending_q && !bank_swap;
  assign accept_c   = in_ready_c && s.in_valid;
  assign x_col_c    = x_q[32'(col_q)*DW +: DW];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      prod_c[r]    = w_q[active_bank_q][r][col_q] * x_col_c;
      acc_sum_c[r] = acc_q[r] + AW'(prod_c[r]);
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    mvm_sat_relu #(.AW(AW), .ACC_W(ACC_W), .SAT_EN(SAT_EN)) u_sat (
      .acc_i  (acc_sum_c[g]),
      .relu_i (relu_q),
      .y_o    (res_sat_c[g*ACC_W +: ACC_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    for (int r = 0; r < ROWS; r++) acc_d[r] = acc_q[r];
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = COMPUTE;
          col_d   = '0;
          for (int r = 0; r < ROWS; r++) acc_d[r] = '0;
        end
      end
      COMPUTE: begin
        for (int r = 0; r < ROWS; r++) acc_d[r] = acc_sum_c[r];
        col_d = col_q + COL_W'(1);
        // Last column: the narrowed result includes this cycle's products.
        if (col_q == COL_W'(COLS - 1)) begin
          state_d     = OUTPUT;
          out_valid_d = 1'b1;
          res_d       = res_sat_c;
        end
      end
      OUTPUT: begin
        if (s.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Swaps only take effect in IDLE; repeated requests collapse into one.
  always_comb begin
    active_bank_d  = active_bank_q;
    swap_pending_d = swap_pending_q;
    if (swap_pending_q && (state_q == IDLE)) begin
      active_bank_d  = !active_bank_q;
      swap_pending_d = 1'b0;
    end else if (bank_swap) begin
      swap_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      x_q            <= '0;
      relu_q         <= 1'b0;
      col_q          <= '0;
      res_q          <= '0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) w_q[b][r][c] <= '0;
    end else begin
      state_q        <= state_d;
      active_bank_q  <= active_bank_d;
      swap_pending_q <= swap_pending_d;
      col_q          <= col_d;
      res_q          <= res_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= (state_d != IDLE);
      for (int r = 0; r < ROWS; r++) acc_q[r] <= acc_d[r];
      if (accept_c) begin
        x_q    <= s.x_vector_flat;
        relu_q <= s.relu_en;
      end
      if (pre_valid) w_q[!active_bank_q][pre_row][pre_col] <= pre_data;
    end
  end

  assign s.in_ready    = in_ready_c;
  assign s.out_valid   = out_valid_q;
  assign s.result_flat = res_q;
  assign active_bank   = active_bank_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mvm_stream_engine.sv
// Scoreboard bench for mvm_stream_engine: directed vectors, expected results
// queued at issue time and checked by an independent output monitor.
module tb_mvm_stream_engine;
  localparam int DW = 8, ROWS = 8, COLS = 16, ROW_W = 3, COL_W = 4, ACC_W = 16;
  localparam int XW = COLS * DW;
  localparam int RW = ROWS * ACC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pre_valid = 1'b0;
  logic [ROW_W+COL_W-1:0] pre_addr = '0;
  logic signed [DW-1:0] pre_data = '0;
  logic bank_swap = 1'b0;
  logic active_bank, busy;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];
  int basic_y [ROWS] = '{680, 816, 952, 1088, 1224, 1360, 1496, 1632};

  mvm_stream_engine_if #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W)) vif ();

  mvm_stream_engine #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
                      .ACC_W(ACC_W), .SAT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .pre_valid(pre_valid), .pre_addr(pre_addr),
    .pre_data(pre_data), .bank_swap(bank_swap), .s(vif),
    .active_bank(active_bank), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [XW-1:0] xconst(input int v);
    logic [XW-1:0] x;
    for (int c = 0; c < COLS; c++) x[c*DW +: DW] = DW'(v);
    return x;
  endfunction

  function automatic logic [RW-1:0] yrows(input int lo, input int hi);
    logic [RW-1:0] y;
    for (int r = 0; r < ROWS; r++) y[r*ACC_W +: ACC_W] = ACC_W'((r < 4) ? lo : hi);
    return y;
  endfunction

  // mode 0: W = r+c; mode 1: rows 0-3 = 127, rows 4-7 = -128; else W = val.
  task automatic preload(input int mode, input int val);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        pre_valid = 1'b1;
        pre_addr  = {ROW_W'(r), COL_W'(c)};
        case (mode)
          0:       pre_data = DW'(r + c);
          1:       pre_data = (r < 4) ? DW'(127) : DW'(-128);
          default: pre_data = DW'(val);
        endcase
        @(posedge clk); #1;
      end
    pre_valid = 1'b0;
  endtask

  task automatic do_swap();
    bank_swap = 1'b1;
    @(posedge clk); #1;
    bank_swap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [XW-1:0] x, input logic relu, output int t);
    bit ok = 1'b0;
    t = -1;
    vif.in_valid = 1'b1;
    vif.x_vector_flat = x;
    vif.relu_en = relu;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vif.in_ready) begin ok = 1'b1; t = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vif.in_valid = 1'b0;
    if (!ok) check("accept_timeout", RW'(vif.in_ready), RW'(1));
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !vif.out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", RW'(exp_q.size()), '0);
    @(posedge clk); #1;
  endtask

  // Output monitor: latency, hold-stability under backpressure, result order.
  initial begin : monitor
    int acc_t[$];
    bit prev_ov;
    logic [RW-1:0] held;
    prev_ov = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_t.delete();
        prev_ov = 1'b0;
        continue;
      end
      if (vif.in_valid && vif.in_ready) acc_t.push_back(cyc);
      if (vif.out_valid) begin
        if (!prev_ov) begin
          if (acc_t.size() == 0) check("out_valid_unexpected", RW'(vif.out_valid), '0);
          else check("latency", RW'(cyc - acc_t.pop_front()), RW'(COLS + 1));
          held = vif.result_flat;
        end else begin
          check("result_hold", vif.result_flat, held);
        end
        if (vif.out_ready) begin
          if (exp_q.size() == 0) check("result_unexpected", RW'(vif.out_valid), '0);
          else check("result", vif.result_flat, exp_q.pop_front());
        end
      end
      prev_ov = vif.out_valid;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, tp;
    logic [RW-1:0] yb;
    logic [XW-1:0] xb;
    vif.in_valid = 1'b0;
    vif.relu_en = 1'b0;
    vif.x_vector_flat = '0;
    vif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", RW'(vif.in_ready), RW'(1));
    check("rst_out_valid", RW'(vif.out_valid), '0);
    check("rst_busy", RW'(busy), '0);
    check("rst_active_bank", RW'(active_bank), '0);
    check("rst_result", vif.result_flat, '0);
    @(posedge clk); #1;

    // Basic: swap and vector requested together, swap must win.
    preload(0, 0);
    for (int c = 0; c < COLS; c++) xb[c*DW +: DW] = DW'(16 - c);
    for (int r = 0; r < ROWS; r++) yb[r*ACC_W +: ACC_W] = ACC_W'(basic_y[r]);
    exp_q.push_back(yb);
    vif.in_valid = 1'b1;
    vif.x_vector_flat = xb;
    bank_swap = 1'b1;
    @(negedge clk);
    check("swap_priority_in_ready", RW'(vif.in_ready), '0);
    @(posedge clk); #1;
    bank_swap = 1'b0;
    send(xb, 1'b0, t);
    check("basic_active_bank", RW'(active_bank), RW'(1));
    check("basic_busy", RW'(busy), RW'(1));
    drain();

    // Saturation and ReLU.
    preload(1, 0);
    do_swap();
    check("sat_active_bank", RW'(active_bank), '0);
    exp_q.push_back(yrows(32767, -32768));
    send(xconst(127), 1'b0, t);
    exp_q.push_back(yrows(32767, 0));
    send(xconst(127), 1'b1, t);
    drain();

    // Backpressure with the next vector already waiting.
    exp_q.push_back(yrows(32767, -32768));
    exp_q.push_back(yrows(32767, 0));
    vif.out_ready = 1'b0;
    send(xconst(127), 1'b0, t);
    vif.in_valid = 1'b1;
    vif.relu_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vif.out_valid) break;
      @(posedge clk); #1;
    end
    check("bp_out_valid", RW'(vif.out_valid), RW'(1));
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready_low", RW'(vif.in_ready), '0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    vif.out_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_in_ready", RW'(vif.in_ready), '0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_next_accept", RW'(vif.in_ready), RW'(1));
    @(posedge clk); #1;
    vif.in_valid = 1'b0;
    drain();

    // Shadow swap: active all 0, shadow all 1, swap deferred during compute.
    preload(2, 0);
    do_swap();
    check("shadow_active_bank", RW'(active_bank), RW'(1));
    preload(2, 1);
    exp_q.push_back(yrows(0, 0));
    send(xconst(1), 1'b0, t);
    exp_q.push_back(yrows(0, 0));
    send(xconst(1), 1'b0, t);
    repeat (3) @(posedge clk);
    #1 bank_swap = 1'b1;
    @(negedge clk);
    check("swap_busy", RW'(busy), RW'(1));
    @(posedge clk); #1;
    bank_swap = 1'b0;
    @(negedge clk);
    check("swap_deferred", RW'(active_bank), RW'(1));
    @(posedge clk); #1;
    exp_q.push_back(yrows(16, 16));
    send(xconst(1), 1'b0, t);
    check("swap_applied", RW'(active_bank), '0);
    drain();

    // Streaming: four vectors with in_valid held and out_ready high.
    tp = 0;
    for (int k = 0; k < 4; k++) begin
      int v;
      v = (k % 2 == 0) ? (k + 1) : -(k + 1);
      exp_q.push_back(yrows(16 * v, 16 * v));
      send(xconst(v), 1'b0, t);
      if (k > 0) check("stream_spacing", RW'(t - tp), RW'(COLS + 2));
      tp = t;
    end
    drain();

    // Reset during COMPUTE abandons the vector and restores reset state.
    preload(2, 2);
    do_swap();
    check("pre_rst_active_bank", RW'(active_bank), RW'(1));
    send(xconst(1), 1'b0, t);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("post_rst_out_valid", RW'(vif.out_valid), '0);
    check("post_rst_in_ready", RW'(vif.in_ready), RW'(1));
    check("post_rst_active_bank", RW'(active_bank), '0);
    check("post_rst_busy", RW'(busy), '0);
    @(posedge clk); #1;
    exp_q.push_back(yrows(0, 0));
    send(xconst(1), 1'b0, t);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mvm_stream_engine.md
Name: mvm_stream_engine

Overview:
- Parametrised successor to the single-shot mesh matrix-vector top.
- Streams back-to-back signed vectors through a ROWS x COLS weight matrix held in double-buffered banks; one column per cycle, ROWS MACs in parallel.
- Valid/ready handshakes on input vectors and results; per-row saturation and optional ReLU.
- Sits between the activation buffer and the output writeback in the accelerator datapath.

Parameters:
- DW, 8: weight and activation width (signed two's complement).
- ROWS, 8: output rows, equal to the number of parallel MACs.
- COLS, 16: vector length.
- ROW_W, 3: clog2(ROWS).
- COL_W, 4: clog2(COLS).
- ACC_W, 16: output width per row.
- SAT_EN, 1: 1 = saturate to ACC_W; 0 = truncate (keep the low ACC_W bits).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- pre_valid, in, 1: weight write strobe.
- pre_addr, in, ROW_W+COL_W: {row, col}.
- pre_data, in, DW: signed weight.
- bank_swap, in, 1: pulse; requests a swap of the active and shadow banks.
- relu_en, in, 1: clamp negative results to 0; sampled at vector accept.
- in_valid, in, 1: vector valid.
- in_ready, out, 1: engine can accept a vector.
- x_vector_flat, in, COLS*DW: x[c] at bits [c*DW +: DW].
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- result_flat, out, ROWS*ACC_W: y[r] at bits [r*ACC_W +: ACC_W].
- active_bank, out, 1: index of the bank used for compute.
- busy, out, 1: high whenever state is not IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values:
  - state = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - result_flat = 0, active_bank = 0, swap_pending = 0.
  - Both weight banks cleared to 0; internal accumulators, column counter and x latch cleared.
  - Reset mid-compute or mid-output abandons the vector; no output is produced for it.
- Weight preload:
  - Each pre_valid cycle writes W[row][col] in bank (~active_bank).
  - Writes are legal in any state and never disturb the active bank.
- Bank swap:
  - bank_swap sets swap_pending.
  - In IDLE with swap_pending = 1: in_ready = 0; on the next clock active_bank toggles and swap_pending clears.
  - A preload write in the same cycle as the toggle goes to the pre-toggle shadow bank.
  - bank_swap while swap_pending = 1 is absorbed, giving a single swap.
- FSM states: IDLE, COMPUTE, OUTPUT.
  - IDLE: in_ready = !swap_pending. When in_valid && in_ready: latch x_vector_flat and relu_en, clear accumulators, set col = 0, go to COMPUTE.
  - COMPUTE: each cycle, for every r, acc[r] += W[r][col] * x[col], with a full-precision signed product. col increments each cycle. After col = COLS-1 the state goes to OUTPUT. COMPUTE lasts exactly COLS cycles.
  - OUTPUT: result_flat is registered on entry and out_valid = 1. Both hold stable until out_ready. On the handshake cycle: out_valid -> 0, go to IDLE.
- Latency and throughput:
  - Accept at cycle T gives out_valid high at cycle T+COLS+1.
  - Minimum spacing between accepts is COLS+2 cycles when out_ready is held high.
  - in_ready stays low from accept until the cycle after the output handshake.
- Arithmetic:
  - Internal accumulator width AW = 2*DW + COL_W, so accumulation never overflows.
  - If relu_en is latched and acc < 0, the result is 0.
  - Otherwise, with SAT_EN = 1, values above 2^(ACC_W-1)-1 clamp to that value and values below -2^(ACC_W-1) clamp to that value. With SAT_EN = 0, the low ACC_W bits are kept.
- Simultaneous events:
  - in_valid and bank_swap in the same IDLE cycle: the swap has priority, in_ready is 0 and the vector waits.
  - bank_swap during COMPUTE or OUTPUT is deferred until IDLE; the in-flight vector completes on the old bank.

Decomposition:
- Package mvm_pkg: FSM state enum (IDLE, COMPUTE, OUTPUT) and a function computing AW from DW and COL_W.
- Sub-module mvm_sat_relu: combinational AW-to-ACC_W saturate, truncate and ReLU, instantiated once per row via generate.
- Top module: contains the two weight banks, the FSM and the MAC array.

Test Plan:
- Basic:
  - Stimulus: preload bank 1 with W[r][c] = r+c, pulse bank_swap, send x[c] = 16-c.
  - Required: active_bank = 1; y[r] = 136r+680, i.e. y0 = 680, y7 = 1632; out_valid exactly 17 cycles after accept.
- Saturation:
  - Stimulus: rows 0-3 W = 127, rows 4-7 W = -128, all x = 127, SAT_EN = 1.
  - Required: rows 0-3 = 32767, rows 4-7 = -32768.
  - Stimulus: same vector with relu_en = 1.
  - Required: rows 4-7 = 0.
- Backpressure:
  - Stimulus: out_ready held low 5 cycles after out_valid, with in_valid held high.
  - Required: result_flat stable; in_ready stays 0; next accept happens the cycle after the handshake.
- Shadow swap:
  - Stimulus: active bank all 0, shadow bank all 1, x all 1.
  - Required: first result all 0.
  - Stimulus: bank_swap during COMPUTE.
  - Required: that vector still gives 0; the next vector gives 16 on every row.
- Streaming:
  - Stimulus: 4 back-to-back vectors with out_ready = 1.
  - Required: accepts spaced 18 cycles apart; results in order and correct.
- Reset mid-operation:
  - Stimulus: rst_n low for 1 cycle during COMPUTE.
  - Required: out_valid never asserts for that vector; afterwards in_ready = 1, active_bank = 0, and a new vector yields 0.
